// File: rtl/e1_rx_phy_filt.sv
// Multi-channel E1 receive front-end.
// Each channel synchronises its two asynchronous pad rails, deglitches them,
// and produces clean rail levels, rising-edge mark strobes, loss-of-signal
// and a sticky "both rails high" error flag. Channels share only clk/rst_n.
//
// Strobe handshake: rx_hi_stb/rx_lo_stb are single-cycle qualifiers with no
// back-pressure. A strobe is high for exactly one clk cycle, in the cycle
// after the filtered rail rises. It is never issued while both filtered
// rails are high.
module e1_rx_phy_filt #(
    parameter int CHANNELS    = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int LOS_LEN     = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] pad_rx_hi,
    input  logic [CHANNELS-1:0] pad_rx_lo,
    output logic [CHANNELS-1:0] rx_hi,
    output logic [CHANNELS-1:0] rx_lo,
    output logic [CHANNELS-1:0] rx_hi_stb,
    output logic [CHANNELS-1:0] rx_lo_stb,
    output logic [CHANNELS-1:0] los,
    output logic [CHANNELS-1:0] err_both,
    input  logic [CHANNELS-1:0] err_clr
);

    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam int LCW = $clog2(LOS_LEN + 1);
    localparam logic [FCW-1:0] FILT_MAX = FCW'(FILT_LEN - 1);
    localparam logic [LCW-1:0] LOS_MAX  = LCW'(LOS_LEN);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // Index 0 is the positive (hi) rail, index 1 the negative (lo) rail.
        logic [1:0]     pad_s;
        logic [1:0]     rail;
        logic [1:0]     prev_q;
        logic [1:0]     stb_q;
        logic [1:0]     stb_d;
        logic           both_hi;
        logic           err_q;
        logic           err_d;
        logic           los_q;
        logic           los_d;
        logic [LCW-1:0] los_cnt_q;
        logic [LCW-1:0] los_cnt_d;

        assign pad_s = {pad_rx_lo[c], pad_rx_hi[c]};

        for (genvar r = 0; r < 2; r++) begin : g_rail
            logic [SYNC_STAGES-1:0] sync_q;
            logic [FCW-1:0]         cnt_q;
            logic                   filt_q;
            logic                   s;

            assign s       = sync_q[SYNC_STAGES-1];
            assign rail[r] = filt_q;

            // Metastability chain: the pad is shifted in at stage 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], pad_s[r]};
                end
            end

            // Deglitch: the output only flips after FILT_LEN consecutive differing samples.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    filt_q <= 1'b0;
                    cnt_q  <= '0;
                end else if (s == filt_q) begin
                    cnt_q  <= '0;
                end else if (cnt_q == FILT_MAX) begin
                    filt_q <= s;
                    cnt_q  <= '0;
                end else begin
                    cnt_q  <= cnt_q + FCW'(1);
                end
            end
        end

        // Next-state for strobes, sticky error and the LOS counter.
        always_comb begin
            both_hi   = rail[0] & rail[1];
            stb_d     = rail & ~prev_q & {2{~both_hi}};
            err_d     = both_hi | (err_q & ~err_clr[c]);
            los_cnt_d = los_cnt_q;
            los_d     = los_q;
            if (|stb_d) begin
                los_cnt_d = '0;
                los_d     = 1'b0;
            end else begin
                if (los_cnt_q != LOS_MAX) begin
                    los_cnt_d = los_cnt_q + LCW'(1);
                end
                if (los_cnt_d == LOS_MAX) begin
                    los_d = 1'b1;
                end
            end
        end

        // Register strobes, previous rail levels, error flag and LOS state.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_q    <= '0;
                stb_q     <= '0;
                err_q     <= 1'b0;
                los_q     <= 1'b1;
                los_cnt_q <= LOS_MAX;
            end else begin
                prev_q    <= rail;
                stb_q     <= stb_d;
                err_q     <= err_d;
                los_q     <= los_d;
                los_cnt_q <= los_cnt_d;
            end
        end

        assign rx_hi[c]     = rail[0];
        assign rx_lo[c]     = rail[1];
        assign rx_hi_stb[c] = stb_q[0];
        assign rx_lo_stb[c] = stb_q[1];
        assign los[c]       = los_q;
        assign err_both[c]  = err_q;
    end

endmodule

// File: tb/tb_e1_rx_phy_filt.sv
// Bench for e1_rx_phy_filt: directed latency/glitch/LOS/error/reset cases
// plus a random multi-channel run, with a per-channel reference model.
module tb_e1_rx_phy_filt;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FL = 3;
  localparam int LL = 16;
  localparam int W  = 6 * CH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CH-1:0] pad_rx_hi = '0;
  logic [CH-1:0] pad_rx_lo = '0;
  logic [CH-1:0] err_clr = '0;
  logic [CH-1:0] rx_hi, rx_lo, rx_hi_stb, rx_lo_stb, los, err_both;

  e1_rx_phy_filt #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .FILT_LEN(FL), .LOS_LEN(LL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pad_rx_hi(pad_rx_hi), .pad_rx_lo(pad_rx_lo),
    .rx_hi(rx_hi), .rx_lo(rx_lo),
    .rx_hi_stb(rx_hi_stb), .rx_lo_stb(rx_lo_stb),
    .los(los), .err_both(err_both), .err_clr(err_clr)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CH-1:0] m_hi, m_lo, m_hstb, m_lstb, m_los, m_err, m_hprev, m_lprev;
  logic [SS-1:0] m_hsync[CH];
  logic [SS-1:0] m_lsync[CH];
  int m_hrun[CH];
  int m_lrun[CH];
  int m_lcnt[CH];

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_hstb = '0; m_lstb = '0;
    m_los = '1; m_err = '0; m_hprev = '0; m_lprev = '0;
    for (int c = 0; c < CH; c++) begin
      m_hsync[c] = '0; m_lsync[c] = '0;
      m_hrun[c] = 0; m_lrun[c] = 0; m_lcnt[c] = LL;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      logic s_h, s_l, oh, ol, both, hs, ls;
      s_h = m_hsync[c][SS-1];
      s_l = m_lsync[c][SS-1];
      oh = m_hi[c];
      ol = m_lo[c];
      both = oh & ol;
      hs = oh & ~m_hprev[c] & ~both;
      ls = ol & ~m_lprev[c] & ~both;
      m_hprev[c] = oh;
      m_lprev[c] = ol;
      m_hstb[c] = hs;
      m_lstb[c] = ls;
      m_err[c] = both | (m_err[c] & ~err_clr[c]);
      if (hs | ls) begin
        m_lcnt[c] = 0;
        m_los[c] = 1'b0;
      end else begin
        if (m_lcnt[c] < LL) m_lcnt[c]++;
        if (m_lcnt[c] == LL) m_los[c] = 1'b1;
      end
      // a rail flips once the synchronised sample has disagreed FL times in a row
      if (s_h != oh) begin
        m_hrun[c]++;
        if (m_hrun[c] == FL) begin m_hi[c] = s_h; m_hrun[c] = 0; end
      end else m_hrun[c] = 0;
      if (s_l != ol) begin
        m_lrun[c]++;
        if (m_lrun[c] == FL) begin m_lo[c] = s_l; m_lrun[c] = 0; end
      end else m_lrun[c] = 0;
      m_hsync[c] = {m_hsync[c][SS-2:0], pad_rx_hi[c]};
      m_lsync[c] = {m_lsync[c][SS-2:0], pad_rx_lo[c]};
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_step();
      exp_q.push_back({m_hi, m_lo, m_hstb, m_lstb, m_los, m_err});
    end
  end

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      check("sb_outs", {8'h0, rx_hi, rx_lo, rx_hi_stb, rx_lo_stb, los, err_both}, {8'h0, sb_exp});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_pad(input int ch, input bit lo_rail, input logic v);
    if (lo_rail) pad_rx_lo[ch] = v;
    else pad_rx_hi[ch] = v;
  endtask

  task automatic pulse(input int ch, input bit lo_rail, input int len);
    @(negedge clk);
    set_pad(ch, lo_rail, 1'b1);
    repeat (len) @(negedge clk);
    set_pad(ch, lo_rail, 1'b0);
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    report();
    $finish;
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n, n_s, n_r;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_los", los, 4'hF);
    check("rst_rails", {rx_hi, rx_lo}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_los", los, 4'hF);
    check("post_rst_err", err_both, 4'h0);
    check("post_rst_stb", {rx_hi_stb, rx_lo_stb}, 8'h00);

    // latency: pad edge to filtered rail = SS + FL edges
    pad_rx_hi[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (rx_hi[0]) break;
    end
    check("lat_hi0", n, SS + FL);
    check("stb_in_rise_cycle", rx_hi_stb[0], 1'b0);
    @(negedge clk);
    check("stb_hi0", rx_hi_stb[0], 1'b1);
    check("los_clear", los[0], 1'b0);
    pad_rx_hi[0] = 1'b0;
    @(negedge clk);
    check("stb_one_cycle", rx_hi_stb[0], 1'b0);
    repeat (14) @(negedge clk);
    check("los_before_len", los[0], 1'b0);
    @(negedge clk);
    check("los_at_len", los[0], 1'b1);

    // glitch rejection on ch1 lo rail
    n_s = 0; n_r = 0;
    for (int len = 1; len <= 2; len++) begin
      pulse(1, 1'b1, len);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        n_s += rx_lo_stb[1];
        n_r += rx_lo[1];
      end
    end
    check("glitch_rail", n_r, 0);
    check("glitch_stb", n_s, 0);
    pulse(1, 1'b1, FL);
    n_s = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_s += rx_lo_stb[1];
    end
    check("pulse3_stb", n_s, 1);

    // 2-cycle dropout inside a held-high rail
    @(negedge clk);
    pad_rx_lo[1] = 1'b1;
    repeat (10) @(negedge clk);
    check("hold_rail", rx_lo[1], 1'b1);
    pad_rx_lo[1] = 1'b0;
    repeat (2) @(negedge clk);
    pad_rx_lo[1] = 1'b1;
    n_s = 0; n_r = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_r += !rx_lo[1];
      n_s += rx_lo_stb[1];
    end
    check("dropout_low", n_r, 0);
    check("dropout_stb", n_s, 0);
    pad_rx_lo[1] = 1'b0;
    repeat (12) @(negedge clk);

    // marks every 10 cycles on ch2 keep los low
    n_s = 0; n_r = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i >= 15) n_r += los[2];
      n_s += rx_hi_stb[2];
      pad_rx_hi[2] = ((i % 10) < 4);
    end
    pad_rx_hi[2] = 1'b0;
    check("marks_los", n_r, 0);
    check("marks_stb", n_s, 8);
    repeat (10) @(negedge clk);

    // illegal state on ch0: both pads high for 6 cycles
    n_s = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_s += rx_hi_stb[0] + rx_lo_stb[0];
      pad_rx_hi[0] = (i < 6);
      pad_rx_lo[0] = (i < 6);
    end
    check("both_no_stb", n_s, 0);
    check("both_err0", err_both[0], 1'b1);
    check("both_err1", err_both[1], 1'b0);
    err_clr[0] = 1'b1;
    @(negedge clk);
    err_clr[0] = 1'b0;
    check("err_clr", err_both[0], 1'b0);

    // err_clr in the first illegal cycle: set wins
    pad_rx_hi[0] = 1'b1;
    pad_rx_lo[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_hi[0] & rx_lo[0]) break;
    end
    check("overlap_seen", {rx_hi[0], rx_lo[0], err_both[0]}, 3'b110);
    err_clr[0] = 1'b1;
    @(negedge clk);
    err_clr[0] = 1'b0;
    check("set_wins", err_both[0], 1'b1);
    pad_rx_hi[0] = 1'b0;
    pad_rx_lo[0] = 1'b0;
    repeat (10) @(negedge clk);
    err_clr = '1;
    @(negedge clk);
    err_clr = '0;
    repeat (5) @(negedge clk);

    // async reset with ch2 strobe live and ch3 filter mid-count
    pad_rx_hi[2] = 1'b1;
    repeat (2) @(negedge clk);
    pad_rx_hi[3] = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_rst_stb2", rx_hi_stb[2], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rails", {rx_hi, rx_lo}, 8'h00);
    check("arst_stb", {rx_hi_stb, rx_lo_stb}, 8'h00);
    check("arst_los_err", {los, err_both}, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; n_s = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (rx_hi[3]) break;
      n_s += $countones({rx_hi_stb, rx_lo_stb});
    end
    check("arst_relat", n, SS + FL);
    check("arst_no_stb", n_s, 0);
    pad_rx_hi = '0;
    repeat (10) @(negedge clk);

    // random independent streams on all channels
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) pad_rx_hi[c] = ~pad_rx_hi[c];
        if ($urandom_range(0, 5) == 0) pad_rx_lo[c] = ~pad_rx_lo[c];
        err_clr[c] = ($urandom_range(0, 15) == 0);
      end
    end
    err_clr = '0;
    repeat (5) @(negedge clk);
    report();
    $finish;
  end
endmodule
